// File: rtl/pcm_pwm_out.sv
// PCM-to-PWM audio output: 2-entry sample FIFO feeding an 8-bit PWM whose
// duty is reloaded once every REPEAT 256-clock periods.
module pcm_pwm_out #(
  parameter int unsigned REPEAT    = 4,
  parameter logic [7:0]  IDLE_DUTY = 8'h80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] pcm_in,
  input  logic       pcm_in_vld,
  output logic       pcm_in_rdy,
  input  logic       underrun_clr,
  output logic       pwm_out,
  output logic       sample_tick,
  output logic       underrun,
  output logic [7:0] duty
);

  localparam int unsigned REP_W = 4;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT - 1);

  logic [7:0]       cnt_q, cnt_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [7:0]       duty_q, duty_d;
  logic [1:0][7:0]  mem_q, mem_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             underrun_q, underrun_d;

  logic full_c, empty_c, push_c, pop_c, boundary_c;

  // Handshake, boundary detection and next-state logic.
  always_comb begin
    full_c     = (count_q == 2'd2);
    empty_c    = (count_q == 2'd0);
    pcm_in_rdy = !full_c && !reset;
    push_c     = pcm_in_vld && pcm_in_rdy;
    boundary_c = !reset && en && (cnt_q == 8'hFF) && (rep_q == REP_LAST);
    pop_c      = boundary_c && !empty_c;

    cnt_d      = cnt_q;
    rep_d      = rep_q;
    duty_d     = duty_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    underrun_d = underrun_q;

    if (en) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_q == 8'hFF) begin
        rep_d = (rep_q == REP_LAST) ? '0 : rep_q + REP_W'(1);
      end
    end

    // Pop decision uses the pre-push occupancy, so a push in a boundary
    // cycle into an empty FIFO still counts as an underrun.
    if (pop_c) begin
      duty_d   = mem_q[rd_ptr_q];
      rd_ptr_d = !rd_ptr_q;
    end
    if (push_c) begin
      mem_d[wr_ptr_q] = pcm_in;
      wr_ptr_d        = !wr_ptr_q;
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (boundary_c && empty_c) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      rep_q      <= '0;
      duty_q     <= IDLE_DUTY;
      mem_q      <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      rep_q      <= rep_d;
      duty_q     <= duty_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    pwm_out     = en && (cnt_q < duty_q);
    sample_tick = boundary_c;
    underrun    = underrun_q;
    duty        = duty_q;
  end

endmodule

// File: tb/tb_pcm_pwm_out.sv
// Self-checking bench for pcm_pwm_out: directed scenarios plus random traffic
// compared against a period/queue level reference model.
module tb_pcm_pwm_out;

  localparam int unsigned REPEAT = 4;
  localparam int unsigned PER    = REPEAT * 256;
  localparam logic [7:0]  IDLE   = 8'h80;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [7:0] pcm_in = 8'h00;
  logic       pcm_in_vld = 1'b0;
  logic       underrun_clr = 1'b0;
  logic       pcm_in_rdy, pwm_out, sample_tick, underrun;
  logic [7:0] duty;

  int n_checks = 0;
  int n_pass   = 0;

  pcm_pwm_out #(.REPEAT(REPEAT), .IDLE_DUTY(IDLE)) dut (
    .clk(clk), .reset(reset), .en(en), .pcm_in(pcm_in), .pcm_in_vld(pcm_in_vld),
    .pcm_in_rdy(pcm_in_rdy), .underrun_clr(underrun_clr), .pwm_out(pwm_out),
    .sample_tick(sample_tick), .underrun(underrun), .duty(duty)
  );

  always #5 clk = ~clk;

  // Reference model: position inside the sample period, playing duty, queue.
  int         m_phase = 0;
  logic [7:0] m_duty = IDLE;
  logic [7:0] m_q[$];
  logic       m_ur = 1'b0;
  bit         m_bnd, m_acc, m_set;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_duty = IDLE; m_q.delete(); m_ur = 1'b0;
    end else begin
      m_bnd = en && (m_phase == PER - 1);
      m_acc = pcm_in_vld && (m_q.size() < 2);
      m_set = m_bnd && (m_q.size() == 0);
      if (m_bnd && m_q.size() != 0) m_duty = m_q.pop_front();
      if (m_acc) m_q.push_back(pcm_in);
      if (en) m_phase = (m_phase + 1) % PER;
      if (m_set) m_ur = 1'b1;
      else if (underrun_clr) m_ur = 1'b0;
    end
  end

  function automatic logic exp_pwm();
    return en && ((m_phase % 256) < int'(m_duty));
  endfunction
  function automatic logic exp_tick();
    return !reset && en && (m_phase == PER - 1);
  endfunction
  function automatic logic exp_rdy();
    return !reset && (m_q.size() < 2);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; pcm_in_vld = 1'b0; underrun_clr = 1'b0;
    repeat (3) next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int ticks;
    reset = 1'b1; en = 1'b1; pcm_in_vld = 1'b1; pcm_in = 8'h11;
    repeat (3) next_cycle();
    @(negedge clk);
    n_checks++; if (pcm_in_rdy !== 1'b0) $display("FAIL rst_rdy: got %0h expected 0", pcm_in_rdy); else n_pass++;
    n_checks++; if (sample_tick !== 1'b0) $display("FAIL rst_tick: got %0h expected 0", sample_tick); else n_pass++;
    n_checks++; if (duty !== IDLE) $display("FAIL rst_duty: got %0h expected %0h", duty, IDLE); else n_pass++;
    n_checks++; if (underrun !== 1'b0) $display("FAIL rst_underrun: got %0h expected 0", underrun); else n_pass++;
    next_cycle();
    reset = 1'b0; pcm_in_vld = 1'b0;
    @(negedge clk);
    n_checks++; if (pcm_in_rdy !== 1'b1) $display("FAIL rst_rel_rdy: got %0h expected 1", pcm_in_rdy); else n_pass++;
    n_checks++; if (pwm_out !== 1'b1) $display("FAIL rst_rel_pwm: got %0h expected 1", pwm_out); else n_pass++;
    next_cycle();
    // Buffer two samples, then reset mid-period: they must be discarded.
    for (int c = 1; c < 500; c++) begin
      pcm_in_vld = (c < 3); pcm_in = 8'(8'h20 + c);
      next_cycle();
    end
    reset = 1'b1; pcm_in_vld = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++; if (sample_tick !== 1'b0) $display("FAIL midrst_tick: got %0h expected 0", sample_tick); else n_pass++;
      next_cycle();
    end
    reset = 1'b0;
    ticks = 0;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      if (sample_tick) ticks++;
      n_checks++; if (pwm_out !== exp_pwm()) $display("FAIL midrst_pwm c=%0d: got %0h expected %0h", c, pwm_out, exp_pwm()); else n_pass++;
      n_checks++; if (sample_tick !== (c == 1023)) $display("FAIL midrst_tick c=%0d: got %0h expected %0h", c, sample_tick, (c == 1023)); else n_pass++;
      next_cycle();
    end
    n_checks++; if (ticks != 1) $display("FAIL midrst_nticks: got %0d expected 1", ticks); else n_pass++;
    n_checks++; if (duty !== IDLE) $display("FAIL midrst_duty: got %0h expected %0h", duty, IDLE); else n_pass++;
    n_checks++; if (underrun !== 1'b1) $display("FAIL midrst_underrun: got %0h expected 1", underrun); else n_pass++;
  endtask

  task automatic test_idle();
    int highs;
    do_reset();
    en = 1'b1; highs = 0;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      if (pwm_out) highs++;
      if (c < 1024 && c % 256 == 255) begin
        n_checks++; if (highs != 128) $display("FAIL idle_highs c=%0d: got %0d expected 128", c, highs); else n_pass++;
        highs = 0;
      end
      n_checks++; if (sample_tick !== (c == 1023)) $display("FAIL idle_tick c=%0d: got %0h expected %0h", c, sample_tick, (c == 1023)); else n_pass++;
      n_checks++; if (underrun !== (c >= 1024)) $display("FAIL idle_underrun c=%0d: got %0h expected %0h", c, underrun, (c >= 1024)); else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_two_samples();
    int highs;
    do_reset();
    en = 1'b1; highs = 0;
    for (int c = 0; c < 3074; c++) begin
      pcm_in_vld = (c < 2); pcm_in = (c == 0) ? 8'h40 : 8'hC0;
      @(negedge clk);
      if (pwm_out) highs++;
      if (c == 2) begin
        n_checks++; if (pcm_in_rdy !== 1'b0) $display("FAIL two_rdy: got %0h expected 0", pcm_in_rdy); else n_pass++;
      end
      if (c == 1024) begin
        n_checks++; if (duty !== 8'h40) $display("FAIL two_duty1: got %0h expected 40", duty); else n_pass++;
      end
      if (c == 2048) begin
        n_checks++; if (duty !== 8'hC0) $display("FAIL two_duty2: got %0h expected c0", duty); else n_pass++;
      end
      if (c <= 3071) begin
        n_checks++; if (underrun !== 1'b0) $display("FAIL two_underrun c=%0d: got %0h expected 0", c, underrun); else n_pass++;
      end
      if (c % 256 == 255) begin
        if (c >= 1024 && c < 3072) begin
          n_checks++; if (highs != ((c < 2048) ? 64 : 192)) $display("FAIL two_highs c=%0d: got %0d expected %0d", c, highs, (c < 2048) ? 64 : 192); else n_pass++;
        end
        highs = 0;
      end
      n_checks++; if (pwm_out !== exp_pwm()) $display("FAIL two_pwm c=%0d: got %0h expected %0h", c, pwm_out, exp_pwm()); else n_pass++;
      next_cycle();
    end
    n_checks++; if (underrun !== 1'b1) $display("FAIL two_underrun_end: got %0h expected 1", underrun); else n_pass++;
  endtask

  task automatic test_extremes();
    int highs;
    do_reset();
    en = 1'b1; highs = 0;
    for (int c = 0; c < 3072; c++) begin
      pcm_in_vld = (c < 2); pcm_in = (c == 0) ? 8'h00 : 8'hFF;
      @(negedge clk);
      if (pwm_out) highs++;
      if (c >= 2048 && c % 256 == 255) begin
        n_checks++; if (pwm_out !== 1'b0) $display("FAIL ext_low255 c=%0d: got %0h expected 0", c, pwm_out); else n_pass++;
      end
      if (c % 256 == 255) begin
        if (c >= 1024) begin
          n_checks++; if (highs != ((c < 2048) ? 0 : 255)) $display("FAIL ext_highs c=%0d: got %0d expected %0d", c, highs, (c < 2048) ? 0 : 255); else n_pass++;
        end
        highs = 0;
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic       acc, seen;
    logic [7:0] last;
    int         accepts;
    do_reset();
    en = 1'b1; pcm_in_vld = 1'b1; pcm_in = 8'h00;
    seen = 1'b0; last = IDLE; accepts = 0;
    for (int c = 0; c < 5200; c++) begin
      @(negedge clk);
      acc = pcm_in_rdy;
      if (c >= 3100 && c < 4124 && acc) accepts++;
      n_checks++; if (pcm_in_rdy !== exp_rdy()) $display("FAIL b2b_rdy c=%0d: got %0h expected %0h", c, pcm_in_rdy, exp_rdy()); else n_pass++;
      n_checks++; if (duty !== m_duty) $display("FAIL b2b_duty c=%0d: got %0h expected %0h", c, duty, m_duty); else n_pass++;
      if (duty !== last) begin
        if (seen) begin
          n_checks++; if (duty !== 8'(last + 8'd1)) $display("FAIL b2b_order c=%0d: got %0h expected %0h", c, duty, 8'(last + 8'd1)); else n_pass++;
        end
        seen = 1'b1; last = duty;
      end
      next_cycle();
      if (acc) pcm_in = pcm_in + 8'd1;
    end
    pcm_in_vld = 1'b0;
    n_checks++; if (accepts != 1) $display("FAIL b2b_accepts: got %0d expected 1", accepts); else n_pass++;
    n_checks++; if (duty !== 8'h04) $display("FAIL b2b_final_duty: got %0h expected 04", duty); else n_pass++;
  endtask

  task automatic test_underrun_clr();
    do_reset();
    en = 1'b1;
    for (int c = 0; c < 2200; c++) begin
      underrun_clr = (c == 2047) || (c == 2100);
      @(negedge clk);
      if (c == 2048 || c == 2100) begin
        n_checks++; if (underrun !== 1'b1) $display("FAIL ur_hold c=%0d: got %0h expected 1", c, underrun); else n_pass++;
      end
      if (c == 2101) begin
        n_checks++; if (underrun !== 1'b0) $display("FAIL ur_clear: got %0h expected 0", underrun); else n_pass++;
      end
      n_checks++; if (underrun !== m_ur) $display("FAIL ur_model c=%0d: got %0h expected %0h", c, underrun, m_ur); else n_pass++;
      next_cycle();
    end
    underrun_clr = 1'b0;
  endtask

  task automatic test_enable_gap();
    int g;
    do_reset();
    g = 200 + int'($urandom_range(0, 500));
    for (int c = 0; c < 2150; c++) begin
      en = !(c >= g && c < g + 100);
      pcm_in_vld = (c == 0) || (c == g + 10) || (c == g + 11);
      pcm_in = (c == 0) ? 8'h30 : ((c == g + 10) ? 8'h50 : 8'h70);
      @(negedge clk);
      if (!en) begin
        n_checks++; if (pwm_out !== 1'b0) $display("FAIL gap_pwm c=%0d: got %0h expected 0", c, pwm_out); else n_pass++;
        n_checks++; if (duty !== IDLE) $display("FAIL gap_duty c=%0d: got %0h expected %0h", c, duty, IDLE); else n_pass++;
      end
      if (c == g + 10 || c == g + 11) begin
        n_checks++; if (pcm_in_rdy !== (c == g + 10)) $display("FAIL gap_rdy c=%0d: got %0h expected %0h", c, pcm_in_rdy, (c == g + 10)); else n_pass++;
      end
      n_checks++; if (sample_tick !== (c == 1123 || c == 2147)) $display("FAIL gap_tick c=%0d: got %0h expected %0h", c, sample_tick, (c == 1123 || c == 2147)); else n_pass++;
      if (c == 1124) begin
        n_checks++; if (duty !== 8'h30) $display("FAIL gap_duty1: got %0h expected 30", duty); else n_pass++;
      end
      next_cycle();
    end
    n_checks++; if (duty !== 8'h50) $display("FAIL gap_duty2: got %0h expected 50", duty); else n_pass++;
    en = 1'b1; pcm_in_vld = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 8000; c++) begin
      en           = ($urandom_range(0, 19) != 0);
      pcm_in_vld   = ($urandom_range(0, 2) == 0);
      pcm_in       = 8'($urandom);
      underrun_clr = ($urandom_range(0, 199) == 0);
      reset        = ($urandom_range(0, 2999) == 0);
      @(negedge clk);
      n_checks++; if (pwm_out !== exp_pwm()) $display("FAIL rnd_pwm c=%0d: got %0h expected %0h", c, pwm_out, exp_pwm()); else n_pass++;
      n_checks++; if (sample_tick !== exp_tick()) $display("FAIL rnd_tick c=%0d: got %0h expected %0h", c, sample_tick, exp_tick()); else n_pass++;
      n_checks++; if (pcm_in_rdy !== exp_rdy()) $display("FAIL rnd_rdy c=%0d: got %0h expected %0h", c, pcm_in_rdy, exp_rdy()); else n_pass++;
      n_checks++; if (duty !== m_duty) $display("FAIL rnd_duty c=%0d: got %0h expected %0h", c, duty, m_duty); else n_pass++;
      n_checks++; if (underrun !== m_ur) $display("FAIL rnd_underrun c=%0d: got %0h expected %0h", c, underrun, m_ur); else n_pass++;
      next_cycle();
    end
    reset = 1'b0; pcm_in_vld = 1'b0; underrun_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_two_samples();
    test_extremes();
    test_back_to_back();
    test_underrun_clr();
    test_enable_gap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pcm_pwm_out.md
PCM_PWM_OUT -- requirements
Module: pcm_pwm_out

Interface
REQ-001 Parameter: REPEAT, default 4, number of 256-clock PWM periods per PCM sample (legal range 1..16).
REQ-002 Parameter: IDLE_DUTY, default 8'h80, duty loaded at reset (mid-scale silence).
REQ-003 Ports: clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 Ports: reset, input, 1, synchronous, active-high.
REQ-005 Ports: en, input, 1, run enable.
REQ-006 Ports: pcm_in, input, 8, unsigned PCM sample from the bytebeat generator.
REQ-007 Ports: pcm_in_vld, input, 1, sample valid.
REQ-008 Ports: pcm_in_rdy, output, 1, block can accept a sample.
REQ-009 Ports: underrun_clr, input, 1, clears the sticky underrun flag.
REQ-010 Ports: pwm_out, output, 1, PWM audio bit.
REQ-011 Ports: sample_tick, output, 1, one-cycle pulse at each sample boundary.
REQ-012 Ports: underrun, output, 1, sticky underrun flag.
REQ-013 Ports: duty, output, 8, currently playing sample.

Function
REQ-014 Input buffer SHALL be a 2-entry FIFO; pcm_in_rdy = !full && !reset; transfer occurs when pcm_in_vld && pcm_in_rdy.
REQ-015 FIFO SHALL preserve order; with no bypass, a sample pushed in cycle N becomes poppable in cycle N+1 at the earliest.
REQ-016 Push and pop in the same cycle with 1 entry SHALL leave the count at 1; when full, push SHALL be refused (rdy=0) even if a pop occurs that cycle.
REQ-017 An 8-bit counter cnt SHALL increment by 1 each cycle while en=1, wrapping 255->0.
REQ-018 A rep counter (0..REPEAT-1) SHALL increment when cnt wraps, wrapping REPEAT-1->0.
REQ-019 A boundary SHALL occur in a cycle where en=1, cnt=255 and rep=REPEAT-1; sample_tick SHALL be 1 exactly in those cycles.
REQ-020 At a boundary with the FIFO non-empty: pop the head; duty takes the head value in the next cycle.
REQ-021 At a boundary with the FIFO empty: duty SHALL be held and underrun set to 1 in the next cycle.
REQ-022 A push into an empty FIFO in a boundary cycle SHALL still cause an underrun; the pushed sample plays at the following boundary.
REQ-023 pwm_out SHALL be (cnt < duty) while en=1, as an unsigned compare: duty 0 -> constant 0; duty 255 -> high 255 of 256 cycles.
REQ-024 While en=0: cnt, rep and duty SHALL freeze; pwm_out=0; sample_tick=0; the FIFO SHALL still accept pushes.
REQ-025 underrun_clr=1 SHALL clear underrun in the next cycle; if a set condition occurs in the same cycle, the set wins.
REQ-026 Total latency (accepted sample to pwm_out reflecting it) SHALL be bounded by 2*REPEAT*256+1 cycles with a full FIFO.

Reset
REQ-027 While reset=1: cnt=0, rep=0, duty=IDLE_DUTY, FIFO empty, underrun=0, pcm_in_rdy=0, sample_tick=0; input transfers SHALL be ignored.
REQ-028 In the first cycle after reset=0: pcm_in_rdy=1, and pwm_out=1 (cnt=0 < 0x80).
REQ-029 Reset asserted mid-period SHALL discard buffered samples and restart from cnt=0 with no sample_tick.

Verification
REQ-030 Reset, en=1, no input -> pwm_out high 128 of every 256 cycles; first sample_tick at cycle 1023; underrun=1 from cycle 1024.
REQ-031 Push 0x40 then 0xC0 after reset -> rdy drops to 0 after the 2nd push; duty=0x40 at cycle 1024 and 0xC0 at cycle 2048; pwm_out high 64 then 192 cycles per period; underrun stays 0 through cycle 3071.
REQ-032 Hold pcm_in_vld=1 continuously with an incrementing value -> exactly one accept per 1024 cycles in steady state; duty sequence is in order with no gaps.
REQ-033 Push 0x00 and 0xFF -> pwm_out constant 0 for 1024 cycles, then 255 high cycles per period with a single low at cnt=255.
REQ-034 Set underrun, then underrun_clr=1 coincident with an empty-FIFO boundary -> underrun stays 1; clear in a non-boundary cycle -> 0 the next cycle.
REQ-035 Drop en for 100 cycles mid-period, with FIFO pushes during that window -> cnt/duty frozen, pwm_out=0, pushes accepted; on resume, the next boundary occurs 100 cycles later than nominal.
